// File: rtl/fft_ctrl_pkg.sv
// Shared control definitions for the FFT stage sequencer: state encoding and
// default geometry of the butterfly pipeline.
package fft_ctrl_pkg;

   localparam int DEF_NUM_STAGES = 4;    // butterfly stages in the pipeline
   localparam int DEF_BEATS      = 32;   // beats per frame (512 points / 16 lanes)
   localparam int DEF_STAGE_LAT  = 1;    // enable-to-output cycles of one stage
   localparam int LANES          = 16;   // complex samples carried per beat

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } seq_state_t;

endpackage

// File: rtl/fft_valid_delay.sv
// Valid strobe plus beat index delay line modelling one butterfly stage.
// The index travels with its valid bit so twiddle addressing never has to be
// recomputed downstream.
module fft_valid_delay #(
   parameter int LAT = 1,
   parameter int W   = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_vld,
   input  logic [W-1:0] i_idx,
   output logic         o_vld,
   output logic [W-1:0] o_idx,
   output logic         o_any
);

   logic [LAT-1:0]        r_vld;
   logic [LAT-1:0][W-1:0] r_idx;

   // Shift valid and index together; a clear drops every beat in the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         r_idx <= '0;
      end else begin
         if (i_clr) begin
            r_vld <= '0;
         end else begin
            r_vld[0] <= i_vld;
            for (int i = 1; i < LAT; i++) r_vld[i] <= r_vld[i-1];
         end
         r_idx[0] <= i_idx;
         for (int i = 1; i < LAT; i++) r_idx[i] <= r_idx[i-1];
      end
   end

   assign o_vld = r_vld[LAT-1];
   assign o_idx = r_idx[LAT-1];
   assign o_any = |r_vld;

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences beats of a streaming FFT frame through NUM_STAGES butterfly
// stages: per-stage enables and twiddle beat indices, frame boundaries,
// flush/abort handling and a completed-frame counter.
module fft_stage_sequencer
   import fft_ctrl_pkg::*;
#(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int BEATS      = DEF_BEATS,
   parameter int STAGE_LAT  = DEF_STAGE_LAT,
   // Derived width of the beat index; not meant to be overridden.
   parameter int CNT_W      = $clog2(BEATS)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             flush,
   output logic [NUM_STAGES-1:0]            stage_en,
   output logic [NUM_STAGES-1:0][CNT_W-1:0] stage_beat,
   output logic                             out_valid,
   output logic                             frame_start,
   output logic                             frame_done,
   output logic                             abort,
   output logic                             busy,
   output logic [15:0]                      frame_cnt
);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   seq_state_t                    r_state;
   logic [CNT_W-1:0]              r_in_cnt;
   logic                          r_v0;
   logic [CNT_W-1:0]              r_b0;
   logic                          r_abort;
   logic [15:0]                   r_frame_cnt;

   logic                          w_accept;
   logic                          w_kill;
   logic                          w_any;
   logic [NUM_STAGES:0]           w_vld;
   logic [NUM_STAGES:0][CNT_W-1:0] w_idx;
   logic [NUM_STAGES-1:0]         w_any_stage;

   // A flush blocks acceptance in the same cycle, so flush always wins.
   assign in_ready    = (r_state != ST_FLUSH) & ~flush;
   assign w_accept    = in_valid & in_ready;
   assign w_kill      = flush & (r_state == ST_RUN);
   assign frame_start = w_accept & (r_in_cnt == '0);

   assign w_vld[0] = r_v0;
   assign w_idx[0] = r_b0;

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      fft_valid_delay #(
         .LAT (STAGE_LAT),
         .W   (CNT_W)
      ) u_dly (
         .clk   (clk),
         .rst   (rst),
         .i_clr (w_kill),
         .i_vld (w_vld[k]),
         .i_idx (w_idx[k]),
         .o_vld (w_vld[k+1]),
         .o_idx (w_idx[k+1]),
         .o_any (w_any_stage[k])
      );
   end

   assign w_any      = r_v0 | (|w_any_stage);
   assign stage_en   = w_vld[NUM_STAGES-1:0];
   assign stage_beat = w_idx[NUM_STAGES-1:0];
   assign out_valid  = w_vld[NUM_STAGES];
   // A flush clears every in-flight beat, so an aborted frame's last beat can
   // never reach the output; index BEATS-1 at the output marks a whole frame.
   assign frame_done = out_valid & (w_idx[NUM_STAGES] == LAST_BEAT);
   assign abort      = r_abort;
   assign busy       = (r_state != ST_IDLE) | w_any;
   assign frame_cnt  = r_frame_cnt;

   // Control FSM, input beat counter, stage-0 register and frame counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_in_cnt    <= '0;
         r_v0        <= 1'b0;
         r_b0        <= '0;
         r_abort     <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_abort <= w_kill & ((r_in_cnt != '0) | w_any);
         r_v0    <= w_accept;
         r_b0    <= r_in_cnt;

         if (w_kill) begin
            r_in_cnt <= '0;
         end else if (w_accept) begin
            r_in_cnt <= (r_in_cnt == LAST_BEAT) ? '0 : r_in_cnt + 1'b1;
         end

         if (frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;

         case (r_state)
            ST_IDLE:  if (w_accept) r_state <= ST_RUN;
            ST_RUN: begin
               if (flush) r_state <= ST_FLUSH;
               else if (!w_any && (r_in_cnt == '0) && !w_accept) r_state <= ST_IDLE;
            end
            ST_FLUSH: if (!w_any) r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer at default parameters
// (4 stages, 32 beats, stage latency 1: accept-to-out_valid latency 5).
module tb_fft_stage_sequencer;

   localparam int NS = 4;
   localparam int BEATS = 32;
   localparam int CW = 5;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    in_valid = 1'b0;
   logic                    flush = 1'b0;
   logic                    in_ready;
   logic [NS-1:0]           stage_en;
   logic [NS-1:0][CW-1:0]   stage_beat;
   logic                    out_valid;
   logic                    frame_start;
   logic                    frame_done;
   logic                    abort;
   logic                    busy;
   logic [15:0]             frame_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_frames = 0;

   fft_stage_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .flush       (flush),
      .stage_en    (stage_en),
      .stage_beat  (stage_beat),
      .out_valid   (out_valid),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .abort       (abort),
      .busy        (busy),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
      tick(); tick();
      in_valid = 1'b1; #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
      n_tests++; if (stage_en !== 4'b0) begin n_fail++; $display("FAIL reset stage_en got %b exp 0", stage_en); end
      n_tests++; if (stage_beat !== '0) begin n_fail++; $display("FAIL reset stage_beat got %h exp 0", stage_beat); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
      n_tests++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL reset frame_start got %b exp 1", frame_start); end
      n_tests++; if (frame_done !== 1'b0 || abort !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset done/abort/busy got %b%b%b exp 000", frame_done, abort, busy); end
      n_tests++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset frame_cnt got %0d exp 0", frame_cnt); end
      in_valid = 1'b0; rst = 1'b0;
      exp_frames = 0;
   endtask

   task automatic test_single_frame();
      logic [NS-1:0] exp_en;
      for (int t = 0; t < 41; t++) begin
         in_valid = (t < 32); #1;
         for (int k = 0; k < NS; k++) exp_en[k] = (t >= 1 + k) && (t <= 32 + k);
         n_tests++; if (stage_en !== exp_en) begin n_fail++; $display("FAIL single stage_en t=%0d got %b exp %b", t, stage_en, exp_en); end
         n_tests++; if (out_valid !== ((t >= 5) && (t <= 36))) begin n_fail++; $display("FAIL single out_valid t=%0d got %b", t, out_valid); end
         n_tests++; if (frame_done !== (t == 36)) begin n_fail++; $display("FAIL single frame_done t=%0d got %b", t, frame_done); end
         n_tests++; if (frame_start !== (t == 0)) begin n_fail++; $display("FAIL single frame_start t=%0d got %b", t, frame_start); end
         tick();
      end
      exp_frames = 1;
      n_tests++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL single frame_cnt got %0d exp %0d", frame_cnt, exp_frames); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single busy_end got %b exp 0", busy); end
   endtask

   task automatic test_back_to_back();
      int n_done;
      int n_out;
      n_done = 0; n_out = 0;
      for (int t = 0; t < 105; t++) begin
         in_valid = (t < 96); #1;
         if (out_valid === 1'b1) n_out++;
         if (frame_done === 1'b1) n_done++;
         n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b in_ready t=%0d got %b exp 1", t, in_ready); end
         n_tests++; if (out_valid !== ((t >= 5) && (t <= 100))) begin n_fail++; $display("FAIL b2b out_valid t=%0d got %b", t, out_valid); end
         n_tests++; if (frame_done !== (t == 36 || t == 68 || t == 100)) begin n_fail++; $display("FAIL b2b frame_done t=%0d got %b", t, frame_done); end
         n_tests++; if (frame_start !== ((t < 96) && (t % 32 == 0))) begin n_fail++; $display("FAIL b2b frame_start t=%0d got %b", t, frame_start); end
         if (t >= 4 && t <= 99) begin
            n_tests++; if (stage_beat[3] !== CW'((t - 4) % 32)) begin n_fail++; $display("FAIL b2b stage_beat3 t=%0d got %0d exp %0d", t, stage_beat[3], (t - 4) % 32); end
         end
         tick();
      end
      exp_frames += 3;
      n_tests++; if (n_out != 96) begin n_fail++; $display("FAIL b2b out_count got %0d exp 96", n_out); end
      n_tests++; if (n_done != 3) begin n_fail++; $display("FAIL b2b done_count got %0d exp 3", n_done); end
      n_tests++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL b2b frame_cnt got %0d exp %0d", frame_cnt, exp_frames); end
   endtask

   task automatic test_gapped();
      int beat_seen;
      beat_seen = 0;
      for (int t = 0; t < 72; t++) begin
         in_valid = (t < 64) && (t % 2 == 0); #1;
         n_tests++; if (out_valid !== ((t >= 5) && (t <= 67) && ((t - 5) % 2 == 0))) begin n_fail++; $display("FAIL gapped out_valid t=%0d got %b", t, out_valid); end
         n_tests++; if (frame_done !== (t == 67)) begin n_fail++; $display("FAIL gapped frame_done t=%0d got %b", t, frame_done); end
         if (stage_en[3] === 1'b1) begin
            n_tests++; if (stage_beat[3] !== CW'(beat_seen)) begin n_fail++; $display("FAIL gapped stage_beat3 t=%0d got %0d exp %0d", t, stage_beat[3], beat_seen); end
            beat_seen++;
         end
         tick();
      end
      exp_frames += 1;
      n_tests++; if (beat_seen != 32) begin n_fail++; $display("FAIL gapped beat_count got %0d exp 32", beat_seen); end
      n_tests++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL gapped frame_cnt got %0d exp %0d", frame_cnt, exp_frames); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gapped busy_end got %b exp 0", busy); end
   endtask

   task automatic test_flush();
      for (int t = 0; t < 10; t++) begin
         in_valid = 1'b1; tick();
      end
      flush = 1'b1; in_valid = 1'b1; #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush in_ready_flushcyc got %b exp 0", in_ready); end
      n_tests++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL flush frame_start_flushcyc got %b exp 0", frame_start); end
      tick();
      flush = 1'b0; in_valid = 1'b0; #1;
      n_tests++; if (abort !== 1'b1) begin n_fail++; $display("FAIL flush abort got %b exp 1", abort); end
      n_tests++; if (stage_en !== 4'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush cleared got %b/%b exp 0/0", stage_en, out_valid); end
      n_tests++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL flush drain ready/busy got %b/%b exp 0/1", in_ready, busy); end
      tick();
      n_tests++; if (in_ready !== 1'b1 || abort !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush idle ready/abort/busy got %b%b%b exp 100", in_ready, abort, busy); end
      for (int t = 0; t < 8; t++) begin
         n_tests++; if (out_valid !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL flush quiet t=%0d got %b/%b exp 0/0", t, out_valid, frame_done); end
         tick();
      end
      for (int t = 0; t < 41; t++) begin
         in_valid = (t < 32); #1;
         n_tests++; if (frame_start !== (t == 0)) begin n_fail++; $display("FAIL flush restart frame_start t=%0d got %b", t, frame_start); end
         if (t >= 1 && t <= 32) begin
            n_tests++; if (stage_en[0] !== 1'b1 || stage_beat[0] !== CW'(t - 1)) begin n_fail++; $display("FAIL flush restart beat0 t=%0d got %b/%0d exp 1/%0d", t, stage_en[0], stage_beat[0], t - 1); end
         end
         n_tests++; if (frame_done !== (t == 36)) begin n_fail++; $display("FAIL flush restart frame_done t=%0d got %b", t, frame_done); end
         tick();
      end
      exp_frames += 1;
      n_tests++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL flush frame_cnt got %0d exp %0d", frame_cnt, exp_frames); end
   endtask

   task automatic test_idle_flush();
      flush = 1'b1; in_valid = 1'b1; #1;
      n_tests++; if (in_ready !== 1'b0 || frame_start !== 1'b0) begin n_fail++; $display("FAIL idleflush ready/start got %b/%b exp 0/0", in_ready, frame_start); end
      tick();
      flush = 1'b0; in_valid = 1'b0; #1;
      n_tests++; if (abort !== 1'b0) begin n_fail++; $display("FAIL idleflush abort got %b exp 0", abort); end
      n_tests++; if (busy !== 1'b0 || stage_en !== 4'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL idleflush busy/en/ready got %b/%b/%b exp 0/0000/1", busy, stage_en, in_ready); end
      in_valid = 1'b1; #1;
      n_tests++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL idleflush next_start got %b exp 1", frame_start); end
      in_valid = 1'b0; #1;
      n_tests++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL idleflush frame_cnt got %0d exp %0d", frame_cnt, exp_frames); end
   endtask

   task automatic test_reset_mid();
      for (int t = 0; t < 20; t++) begin
         in_valid = 1'b1; tick();
      end
      in_valid = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0; #1;
      exp_frames = 0;
      n_tests++; if (stage_en !== 4'b0 || stage_beat !== '0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid pipe got %b/%h/%b exp 0/0/0", stage_en, stage_beat, out_valid); end
      n_tests++; if (frame_done !== 1'b0 || abort !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid done/abort/busy got %b%b%b exp 000", frame_done, abort, busy); end
      n_tests++; if (in_ready !== 1'b1 || frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL rstmid ready/frame_cnt got %b/%0d exp 1/0", in_ready, frame_cnt); end
      for (int t = 0; t < 10; t++) begin
         tick();
         n_tests++; if (out_valid !== 1'b0 || frame_done !== 1'b0 || abort !== 1'b0) begin n_fail++; $display("FAIL rstmid quiet t=%0d got %b%b%b exp 000", t, out_valid, frame_done, abort); end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_gapped();
      test_flush();
      test_idle_flush();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4: number of butterfly stages sequenced.
REQ-002 Parameter BEATS, default 32: 16-lane beats per frame (512-point FFT).
REQ-003 Parameter STAGE_LAT, default 1: cycles from a stage's enable to its output enable.
REQ-004 Ports, with clock and reset first:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  sequencer accepts beat; accept = in_valid & in_ready.
- flush  in  1  single-cycle abort request.
- stage_en  out  NUM_STAGES  per-stage valid strobe, bit k drives stage k.
- stage_beat  out  NUM_STAGES x CNT_W  beat index of the beat at stage k (twiddle address).
- out_valid  out  1  final stage output beat valid.
- frame_start  out  1  pulse on acceptance of beat 0 of a frame.
- frame_done  out  1  pulse with out_valid of beat BEATS-1 of a complete frame.
- abort  out  1  pulse when a flush discards a partial frame.
- busy  out  1  any beat in flight or state not IDLE.
- frame_cnt  out  16  completed frames, wraps at 2^16.

Function
REQ-005 CNT_W SHALL equal clog2(BEATS).
REQ-006 FSM states: IDLE, RUN, FLUSH.
REQ-007 IDLE->RUN on accept; RUN->IDLE when no beat in flight and input beat counter = 0; RUN->FLUSH on flush; IDLE->FLUSH on flush is ignored (stays IDLE, no abort).
REQ-008 FLUSH->IDLE the cycle after the pipeline is empty.
REQ-009 in_ready SHALL be 1 in IDLE and RUN, 0 in FLUSH and in the flush cycle itself.
REQ-010 Input beat counter SHALL increment on accept and wrap BEATS-1 -> 0.
REQ-011 frame_start SHALL be combinational = accept & (input beat counter = 0).
REQ-012 stage_en[0] SHALL be high exactly one cycle after an accept (registered, 1 cycle latency).
REQ-013 stage_en[k] SHALL equal stage_en[0] delayed k*STAGE_LAT cycles; out_valid = stage_en[NUM_STAGES-1] delayed STAGE_LAT cycles.
REQ-014 Accept-to-out_valid latency SHALL be 1 + NUM_STAGES*STAGE_LAT cycles (5 by default), independent of gaps in in_valid.
REQ-015 stage_beat[k] SHALL carry the beat index travelling with stage_en[k] (index pipelined alongside valid, not recomputed).
REQ-016 Back-to-back frames SHALL stream with no idle cycle; beat 0 of frame n+1 may be accepted the cycle after beat BEATS-1 of frame n.
REQ-017 frame_done SHALL pulse with out_valid when that beat's index = BEATS-1 and its frame was not aborted; frame_cnt increments the same cycle.
REQ-018 On flush in RUN: beats already accepted SHALL be discarded — all in-flight valid bits cleared the next cycle, input beat counter cleared, no frame_done for the partial frame.
REQ-019 abort SHALL pulse one cycle after flush if input beat counter != 0 or any beat was in flight; else no pulse.
REQ-020 flush and in_valid in the same cycle: flush wins, beat not accepted.
REQ-021 busy SHALL be state != IDLE or any in-flight valid bit set.

Reset
REQ-022 While rst is high at a clock edge: state IDLE, all valid/beat pipelines, counters, frame_cnt cleared to 0.
REQ-023 Output values after reset: in_ready 1, stage_en 0, stage_beat 0, out_valid 0, frame_start follows in_valid, frame_done 0, abort 0, busy 0, frame_cnt 0.
REQ-024 rst mid-frame SHALL drop all in-flight beats with no frame_done or abort pulse.

Structure
REQ-025 Shared package fft_ctrl_pkg SHALL hold the state enum, NUM_STAGES/BEATS/STAGE_LAT defaults and the 16-lane width constant.
REQ-026 One sub-module, fft_valid_delay (parameterised valid+index delay line), SHALL be instantiated per stage.

Verification
REQ-027 Reset, then 32 consecutive accepts -> stage_en[0] high cycles 1..32, out_valid cycles 5..36, frame_done at cycle 36, frame_cnt=1.
REQ-028 Three frames back-to-back (96 accepts) -> out_valid continuous for 96 cycles, frame_done three times, frame_cnt=3.
REQ-029 in_valid toggling 1/0 for 32 beats -> out_valid pattern identical, shifted 5 cycles; stage_beat[3] sequence 0..31.
REQ-030 flush after 10 accepts -> abort next cycle, in_ready 0 until drained, no frame_done, next frame starts with beat 0.
REQ-031 flush with in_valid same cycle while IDLE -> no accept, no abort, stays IDLE.
REQ-032 rst asserted at beat 20 -> all outputs at reset values next cycle, frame_cnt 0.
